// File: rtl/osiris_vga_pkg.sv
// Framebuffer geometry and capture state encoding shared by the camera
// capture path and the VGA scan-out controller.
package osiris_vga_pkg;

   localparam int FRAMEBUF_WIDTH  = 176;
   localparam int FRAMEBUF_HEIGHT = 144;
   localparam int FB_ADDR_W       = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SYNC,
      ACTIVE,
      DONE
   } cap_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one sensor control pin (S1) and flags its rising/falling edges
// by comparing S1 against the previous S1 value.
module sync_edge (
   input  logic cam_clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic s1_q, s1_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = d;
      prev_d = s1_q;
   end

   always_ff @(posedge cam_clk or posedge reset) begin
      if (reset) begin
         s1_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         prev_q <= prev_d;
      end
   end

   assign q    = s1_q;
   assign rise = s1_q & ~prev_q;
   assign fall = ~s1_q & prev_q;

endmodule

// File: rtl/frame_capture.sv
// Captures one greyscale frame (luma of a YUV422 byte stream) into the framebuffer.
// Optional FRAME_CAPTURE_STATS_EN adds frame_count / err_count outputs.
//
// state  | meaning
// IDLE   | not armed, waiting for capture_start
// ARM    | armed, waiting for vsync rise so capture begins on a whole frame
// SYNC   | inside vsync, waiting for its fall to start the frame
// ACTIVE | writing luma pixels, closing lines on href fall
// DONE   | one-cycle frame_done with frame_err valid
module frame_capture
   import osiris_vga_pkg::*;
#(
   parameter int FB_WIDTH   = FRAMEBUF_WIDTH,
   parameter int FB_HEIGHT  = FRAMEBUF_HEIGHT,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic                 cam_clk,
   input  logic                 reset,
   input  logic                 cam_vsync,
   input  logic                 cam_href,
   input  logic [7:0]           cam_data,
   input  logic                 capture_start,
   output logic                 we,
   output logic [FB_ADDR_W-1:0] addr,
   output logic [7:0]           dout,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_err
`ifdef FRAME_CAPTURE_STATS_EN
   ,
   output logic [15:0]          frame_count,
   output logic [15:0]          err_count
`endif
);

   localparam logic [7:0]           W8        = 8'(FB_WIDTH);
   localparam logic [7:0]           H8        = 8'(FB_HEIGHT);
   localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(FB_WIDTH);

   logic vs_s1, vs_rise, vs_fall;
   logic href_s1, href_rise, href_fall;

   sync_edge u_vsync (
      .cam_clk (cam_clk),
      .reset   (reset),
      .d       (cam_vsync),
      .q       (vs_s1),
      .rise    (vs_rise),
      .fall    (vs_fall)
   );

   sync_edge u_href (
      .cam_clk (cam_clk),
      .reset   (reset),
      .d       (cam_href),
      .q       (href_s1),
      .rise    (href_rise),
      .fall    (href_fall)
   );

   cap_state_e           state_q, state_d;
   logic [7:0]           data_q, data_d;
   logic [1:0]           phase_q, phase_d, cur_phase;
   logic [7:0]           col_q, col_d;
   logic [7:0]           row_q, row_d;
   logic [FB_ADDR_W-1:0] line_base_q, line_base_d;
   logic                 err_q, err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 we_q, we_d;
   logic [FB_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]           dout_q, dout_d;
   logic                 luma;

   always_ff @(posedge cam_clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         data_q      <= '0;
         phase_q     <= '0;
         col_q       <= '0;
         row_q       <= '0;
         line_base_q <= '0;
         err_q       <= 1'b0;
         frame_err_q <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         phase_q     <= phase_d;
         col_q       <= col_d;
         row_q       <= row_d;
         line_base_q <= line_base_d;
         err_q       <= err_d;
         frame_err_q <= frame_err_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture_start) state_d = ARM;
         ARM:     if (vs_rise)       state_d = SYNC;
         SYNC:    if (vs_fall)       state_d = ACTIVE;
         ACTIVE:  if (vs_rise)       state_d = DONE;
         DONE:    state_d = CONTINUOUS ? SYNC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d      = cam_data;
      cur_phase   = href_rise ? 2'd0 : phase_q;
      phase_d     = href_s1 ? cur_phase + 2'd1 : phase_q;
      col_d       = col_q;
      row_d       = row_q;
      line_base_d = line_base_q;
      err_d       = err_q;
      frame_err_d = frame_err_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      dout_d      = dout_q;
      // A byte coinciding with the vsync rise would be written during DONE; drop it.
      luma        = href_s1 && !cur_phase[0] && !vs_s1;

      if (state_q == SYNC && vs_fall) begin
         col_d       = '0;
         row_d       = '0;
         line_base_d = '0;
         err_d       = 1'b0;
         frame_err_d = 1'b0;
      end else if (state_q == ACTIVE) begin
         if (luma) begin
            if (col_q < W8 && row_q < H8) begin
               we_d   = 1'b1;
               addr_d = line_base_q + FB_ADDR_W'(col_q);
               dout_d = data_q;
            end
            col_d = sat_inc8(col_q);
         end
         if (href_fall) begin
            err_d = err_q | (col_q != W8);
            row_d = sat_inc8(row_q);
            if (row_q < H8) line_base_d = line_base_q + LINE_STEP;
            col_d = '0;
         end
         // Line close above is folded in first, so the row check sees the updated row.
         if (vs_rise) begin
            err_d       = err_d | (row_d != H8);
            frame_err_d = err_d;
         end
      end
   end

   always_comb begin
      busy       = (state_q == ARM) || (state_q == SYNC) || (state_q == ACTIVE) ||
                   ((state_q == DONE) && CONTINUOUS);
      frame_done = (state_q == DONE);
   end

   assign we        = we_q;
   assign addr      = addr_q;
   assign dout      = dout_q;
   assign frame_err = frame_err_q;

`ifdef FRAME_CAPTURE_STATS_EN
   logic [15:0] frame_count_q, frame_count_d;
   logic [15:0] err_count_q, err_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      err_count_d   = err_count_q;
      if (state_q == DONE) begin
         frame_count_d = frame_count_q + 16'd1;
         if (frame_err_q && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge cam_clk or posedge reset) begin
      if (reset) begin
         frame_count_q <= '0;
         err_count_q   <= '0;
      end else begin
         frame_count_q <= frame_count_d;
         err_count_q   <= err_count_d;
      end
   end

   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Scoreboard bench for frame_capture: randomized sensor frames against a
// line/pixel reference model, with a single-shot and a continuous instance.
module tb_frame_capture;

   localparam int W = 16;
   localparam int H = 8;

   logic        cam_clk = 1'b0;
   logic        reset;
   logic        cam_vsync, cam_href, capture_start, capture_start_c;
   logic [7:0]  cam_data;
   logic        we, busy, frame_done, frame_err;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic        we_c, busy_c, frame_done_c, frame_err_c;
   logic [15:0] addr_c;
   logic [7:0]  dout_c;
`ifdef FRAME_CAPTURE_STATS_EN
   logic [15:0] frame_count, err_count, frame_count_c, err_count_c;
`endif

   always #5 cam_clk = ~cam_clk;

   frame_capture #(.FB_WIDTH(W), .FB_HEIGHT(H), .CONTINUOUS(1'b0)) dut (
      .cam_clk(cam_clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .capture_start(capture_start),
      .we(we), .addr(addr), .dout(dout), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err)
`ifdef FRAME_CAPTURE_STATS_EN
      , .frame_count(frame_count), .err_count(err_count)
`endif
   );

   frame_capture #(.FB_WIDTH(W), .FB_HEIGHT(H), .CONTINUOUS(1'b1)) dut_c (
      .cam_clk(cam_clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .capture_start(capture_start_c),
      .we(we_c), .addr(addr_c), .dout(dout_c), .busy(busy_c),
      .frame_done(frame_done_c), .frame_err(frame_err_c)
`ifdef FRAME_CAPTURE_STATS_EN
      , .frame_count(frame_count_c), .err_count(err_count_c)
`endif
   );

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t  exp_wr[$];
   logic exp_done[$];
   int   line_len[$];

   int checks = 0;
   int errors = 0;
   // capture model: 0 idle, 1 armed waiting for vsync rise, 2 capturing this frame
   int cap = 0;
   int cap_c = 0;
   bit pending_err = 1'b0;
   int done_exp = 0, err_exp = 0, done_c_exp = 0, done_c_seen = 0;
   bit busy_c_watch = 1'b0, busy_c_dropped = 1'b0;

   always @(negedge cam_clk) begin : monitor
      wr_t  e;
      logic ed;
      if (!reset) begin
         if (we) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write got addr=%0d dout=%0d, none expected", addr, dout);
            end else begin
               e = exp_wr.pop_front();
               if (addr !== e.a || dout !== e.d) begin
                  errors++;
                  $display("FAIL write got addr=%0d dout=%0d, expected addr=%0d dout=%0d",
                           addr, dout, e.a, e.d);
               end
            end
         end
         if (frame_done) begin
            checks++;
            if (exp_done.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_done got frame_err=%0b", frame_err);
            end else begin
               ed = exp_done.pop_front();
               if (frame_err !== ed || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL frame_done got frame_err=%0b busy=%0b, expected frame_err=%0b busy=0",
                           frame_err, busy, ed);
               end
            end
         end
         if (frame_done_c) done_c_seen++;
         if (busy_c_watch && busy_c !== 1'b1) busy_c_dropped = 1'b1;
      end
   end

   task automatic tick();
      @(posedge cam_clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({we, addr, dout, busy, frame_done, frame_err, busy_c, frame_done_c} !== '0) begin
         errors++;
         $display("FAIL %s got we=%0b addr=%0d dout=%0d busy=%0b done=%0b err=%0b busy_c=%0b, expected all 0",
                  name, we, addr, dout, busy, frame_done, frame_err, busy_c);
      end
   endtask

   task automatic vsync_rise_model();
      if (cap == 2) begin
         exp_done.push_back(pending_err);
         done_exp++;
         if (pending_err) err_exp++;
         cap = 0;
      end else if (cap == 1) begin
         cap = 2;
      end
      if (cap_c == 2) done_c_exp++;
      else if (cap_c == 1) cap_c = 2;
   endtask

   task automatic arm(input bit both);
      capture_start = 1'b1;
      if (both) capture_start_c = 1'b1;
      tick();
      capture_start   = 1'b0;
      capture_start_c = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_arm got %0b, expected 1", busy);
      end
      if (cap == 0) cap = 1;
      if (both) begin
         if (cap_c == 0) cap_c = 1;
         busy_c_watch = 1'b1;
      end
   endtask

   task automatic do_reset();
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL writes_before_reset got %0d outstanding, expected 0", exp_wr.size());
      end
      reset = 1'b1;
      #1;
      check_zero("reset_mid_frame");
      exp_wr.delete();
      exp_done.delete();
      cap = 0; cap_c = 0;
      busy_c_watch = 1'b0;
      done_exp = 0; err_exp = 0; done_c_exp = 0; done_c_seen = 0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic set_normal();
      line_len.delete();
      for (int i = 0; i < H; i++) line_len.push_back(W);
   endtask

   task automatic set_random();
      int n;
      line_len.delete();
      n = $urandom_range(H + 1, H - 1);
      for (int i = 0; i < n; i++) line_len.push_back($urandom_range(W + 2, W - 2));
   endtask

   // arm_line / rst_line: line index at whose start capture_start / reset is issued (-1: never)
   task automatic send_frame(input int arm_line, input int rst_line, input bit arm_both);
      bit err;
      int nl;
      nl = line_len.size();
      cam_vsync = 1'b0;
      repeat (2) tick();
      cam_vsync = 1'b1;
      vsync_rise_model();
      repeat (4) tick();
      cam_vsync = 1'b0;
      repeat (3) tick();
      err = (nl != H);
      for (int r = 0; r < nl; r++) begin
         if (r == rst_line) do_reset();
         if (r == arm_line) arm(arm_both);
         if (line_len[r] != W) err = 1'b1;
         cam_href = 1'b1;
         for (int b = 0; b < 2 * line_len[r]; b++) begin
            cam_data = 8'($urandom_range(255, 0));
            if (b % 2 == 0 && cap == 2 && r < H && b / 2 < W)
               exp_wr.push_back('{a: 16'(r * W + b / 2), d: cam_data});
            tick();
         end
         cam_href = 1'b0;
         cam_data = 8'h00;
         repeat (4) tick();
      end
      pending_err = err;
   endtask

   initial begin
      reset = 1'b1;
      cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      capture_start = 1'b0; capture_start_c = 1'b0;
      repeat (3) @(posedge cam_clk);
      #1;
      check_zero("reset_state");
      reset = 1'b0;
      tick();

      arm(1'b1);
      set_normal();                          send_frame(-1, -1, 1'b0); // f0 full frame, captured
      set_normal();                          send_frame(3, -1, 1'b0);  // f1 arm mid-frame, skipped
      set_normal(); line_len[2] = W + 4;     send_frame(5, -1, 1'b0);  // f2 long line, arm while busy
      set_normal(); line_len[4] = W - 5;     send_frame(1, -1, 1'b0);  // f3 skipped, arm mid
      set_normal();
      for (int i = 0; i < 3; i++) line_len.push_back(W);
                                             send_frame(-1, -1, 1'b0); // f4 too many lines
      set_normal();                          send_frame(6, -1, 1'b0);  // f5 skipped, arm mid
      set_normal();
      for (int i = 0; i < 3; i++) void'(line_len.pop_back());
      line_len[1] = W - 3;                   send_frame(-1, -1, 1'b0); // f6 short frame + short line
      set_normal();                          send_frame(2, -1, 1'b0);  // f7 skipped, arm mid
      set_normal();                          send_frame(5, 3, 1'b1);   // f8 reset mid-frame, re-arm both
      set_normal();                          send_frame(-1, -1, 1'b0); // f9 full frame after reset
      set_random();                          send_frame(1, -1, 1'b0);  // f10 skipped, arm mid
      set_random();                          send_frame(-1, -1, 1'b0); // f11 random geometry
      set_normal();                          send_frame(-1, -1, 1'b0); // f12 closes f11
      repeat (10) tick();

      checks++;
      if (exp_wr.size() != 0 || exp_done.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got writes=%0d done=%0d outstanding, expected 0 and 0",
                  exp_wr.size(), exp_done.size());
      end
      checks++;
      if (done_c_seen != done_c_exp || done_c_exp != 3) begin
         errors++;
         $display("FAIL continuous_frame_done got %0d pulses, expected %0d (3 frames)",
                  done_c_seen, done_c_exp);
      end
      checks++;
      if (busy_c_dropped || busy_c !== 1'b1) begin
         errors++;
         $display("FAIL continuous_busy got drop=%0b busy_c=%0b, expected busy held 1",
                  busy_c_dropped, busy_c);
      end
`ifdef FRAME_CAPTURE_STATS_EN
      checks++;
      if (frame_count !== 16'(done_exp) || err_count !== 16'(err_exp)) begin
         errors++;
         $display("FAIL stats got frame_count=%0d err_count=%0d, expected %0d and %0d",
                  frame_count, err_count, done_exp, err_exp);
      end
      checks++;
      if (frame_count_c !== 16'(done_c_exp)) begin
         errors++;
         $display("FAIL stats_continuous got frame_count=%0d, expected %0d",
                  frame_count_c, done_c_exp);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
